// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - shared widths, defaults and FSM encoding for the frequency meter
package freq_meter_pkg;

  localparam int FREQ_W          = 11;
  localparam int DEF_GATE_CYCLES = 50_000_000;
  localparam int DEF_MAX_COUNT   = 2047;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_GATE = 1'b1;

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - two-flop synchronizer plus rising-edge pulse
module sync_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic rise_p
);

  logic meta;
  logic stable;
  logic prev;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta   <= 1'b0;
      stable <= 1'b0;
      prev   <= 1'b0;
    end else begin
      meta   <= async_in;
      stable <= meta;
      prev   <= stable;
    end
  end

  assign rise_p = stable & ~prev;

endmodule

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gated rising-edge counter publishing a saturated 11-bit frequency
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int MAX_COUNT   = DEF_MAX_COUNT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sig_in,
  input  logic              enable,
  output logic [FREQ_W-1:0] freq_out,
  output logic              overflow,
  output logic              update
);

  localparam int                GATE_W    = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [FREQ_W-1:0] MAX_C     = FREQ_W'(MAX_COUNT);

  logic [0:0]        state;
  logic [GATE_W-1:0] gate_cnt;
  logic [FREQ_W-1:0] edge_cnt;
  logic              window_ovf;
  logic              edge_p;

  logic              at_max;
  logic              terminal;
  logic [FREQ_W-1:0] cnt_next;
  logic              ovf_next;

  sync_edge_detect u_sync (
    .clock    (clock),
    .reset    (reset),
    .async_in (sig_in),
    .rise_p   (edge_p)
  );

  // Count including this cycle's edge, so a terminal-cycle edge lands in the result.
  assign at_max   = (edge_cnt == MAX_C);
  assign cnt_next = (edge_p && !at_max) ? edge_cnt + 1'b1 : edge_cnt;
  assign ovf_next = window_ovf | (edge_p & at_max);
  assign terminal = (state == ST_GATE) && (gate_cnt == GATE_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      window_ovf <= 1'b0;
      freq_out   <= '0;
      overflow   <= 1'b0;
      update     <= 1'b0;
    end else begin
      update <= 1'b0;
      if (state == ST_IDLE) begin
        gate_cnt   <= '0;
        edge_cnt   <= '0;
        window_ovf <= 1'b0;
        if (enable) state <= ST_GATE;
      end else if (terminal) begin
        // Publish and start the next window in the same cycle: no dead cycle.
        freq_out   <= cnt_next;
        overflow   <= ovf_next;
        update     <= 1'b1;
        gate_cnt   <= '0;
        edge_cnt   <= '0;
        window_ovf <= 1'b0;
        if (!enable) state <= ST_IDLE;
      end else if (!enable) begin
        state      <= ST_IDLE;
        gate_cnt   <= '0;
        edge_cnt   <= '0;
        window_ovf <= 1'b0;
      end else begin
        gate_cnt   <= gate_cnt + 1'b1;
        edge_cnt   <= cnt_next;
        window_ovf <= ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - two meter instances (100- and 5000-cycle gates) against a window model
module tb_freq_meter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sig   = 1'b0;
  logic        en    = 1'b0;
  logic [10:0] fo_a, fo_b;
  logic        ov_a, ov_b, up_a, up_b;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  freq_meter #(.GATE_CYCLES(100), .MAX_COUNT(2047)) dut_a (
    .clock(clock), .reset(reset), .sig_in(sig), .enable(en),
    .freq_out(fo_a), .overflow(ov_a), .update(up_a)
  );

  freq_meter #(.GATE_CYCLES(5000), .MAX_COUNT(2047)) dut_b (
    .clock(clock), .reset(reset), .sig_in(sig), .enable(en),
    .freq_out(fo_b), .overflow(ov_b), .update(up_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Tone generator: periodic square wave, or a burst of period-2 pulses, else low.
  int cyc = 0;
  int period = 0;
  int ph0 = 0;
  int burst_start = 0;
  int burst_n = 0;

  initial begin
    forever begin
      @(posedge clock);
      cyc++;
      #2;
      if (period > 0)
        sig = (((cyc - ph0) % period) < (period / 2));
      else if (burst_n > 0 && cyc >= burst_start && cyc < burst_start + 2 * burst_n)
        sig = (((cyc - burst_start) % 2) == 0);
      else
        sig = 1'b0;
    end
  end

  // Window model: an edge is counted when the sampled level history shows 0 then 1,
  // three samples late; the raw count is unbounded and clipped only when published.
  int m_act[2], m_k[2], m_cnt[2], e_fo[2], e_ov[2], e_up[2];
  bit hist[4];

  function automatic int gate_len(input int i);
    return (i == 0) ? 100 : 5000;
  endfunction

  initial begin
    bit rise;
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_k[i] = 0; m_cnt[i] = 0; e_fo[i] = 0; e_ov[i] = 0; e_up[i] = 0;
    end
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        for (int i = 0; i < 2; i++) begin
          m_act[i] = 0; m_k[i] = 0; m_cnt[i] = 0; e_fo[i] = 0; e_ov[i] = 0; e_up[i] = 0;
        end
        for (int j = 0; j < 4; j++) hist[j] = 1'b0;
      end else begin
        hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = sig;
        rise = hist[2] && !hist[3];
        for (int i = 0; i < 2; i++) begin
          e_up[i] = 0;
          if (m_act[i] != 0) begin
            m_k[i]++;
            if (rise) m_cnt[i]++;
            if (m_k[i] == gate_len(i)) begin
              e_fo[i]  = (m_cnt[i] > 2047) ? 2047 : m_cnt[i];
              e_ov[i]  = (m_cnt[i] > 2047) ? 1 : 0;
              e_up[i]  = 1;
              m_k[i]   = 0;
              m_cnt[i] = 0;
              if (!en) m_act[i] = 0;
            end else if (!en) begin
              m_act[i] = 0;
            end
          end else if (en) begin
            m_act[i] = 1; m_k[i] = 0; m_cnt[i] = 0;
          end
        end
      end
    end
  end

  always @(negedge clock) begin
    chk("model_fo_a", int'(fo_a), e_fo[0]);
    chk("model_ov_a", int'(ov_a), e_ov[0]);
    chk("model_up_a", int'(up_a), e_up[0]);
    chk("model_fo_b", int'(fo_b), e_fo[1]);
    chk("model_ov_b", int'(ov_b), e_ov[1]);
    chk("model_up_b", int'(up_b), e_up[1]);
  end

  task automatic wait_upd(input int which, input int maxc, output int n);
    n = -1;
    checks++;
    for (int i = 1; i <= maxc; i++) begin
      @(posedge clock);
      #1;
      if ((which == 0 && up_a) || (which == 1 && up_b)) begin
        n = i;
        return;
      end
    end
    errors++;
    $display("FAIL wait_update_%0d: no update within %0d cycles", which, maxc);
  endtask

  initial begin
    int n;
    int n_up;

    repeat (3) @(posedge clock);
    #1;
    chk("reset_fo", int'(fo_a), 0);
    chk("reset_ov", int'(ov_a), 0);
    chk("reset_up", int'(up_a), 0);

    // Reset mid-window.
    reset = 1'b0; en = 1'b1; period = 10; ph0 = cyc;
    repeat (50) @(posedge clock);
    #1; reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("midreset_fo", int'(fo_a), 0);
    chk("midreset_ov", int'(ov_a), 0);
    chk("midreset_up", int'(up_a), 0);
    reset = 1'b0;
    wait_upd(0, 200, n);
    chk("first_update_latency", n, 101);

    // Steady tone.
    for (int w = 0; w < 3; w++) begin
      wait_upd(0, 200, n);
      chk("steady_interval", n, 100);
      chk("steady_fo", int'(fo_a), 10);
      chk("steady_ov", int'(ov_a), 0);
    end

    // Saturation on the long gate, then recovery.
    wait_upd(1, 6000, n);
    period = 2; ph0 = cyc;
    wait_upd(1, 5100, n);
    chk("sat_interval", n, 5000);
    chk("sat_fo", int'(fo_b), 2047);
    chk("sat_ov", int'(ov_b), 1);
    period = 10; ph0 = cyc;
    wait_upd(1, 5100, n);
    wait_upd(1, 5100, n);
    chk("recover_fo", int'(fo_b), 500);
    chk("recover_ov", int'(ov_b), 0);

    // Exact ceiling.
    period = 0;
    wait_upd(1, 5100, n);
    burst_start = cyc + 1; burst_n = 2047;
    wait_upd(1, 5100, n);
    chk("ceil_fo", int'(fo_b), 2047);
    chk("ceil_ov", int'(ov_b), 0);
    burst_start = cyc + 1; burst_n = 2048;
    wait_upd(1, 5100, n);
    chk("ceil_plus1_fo", int'(fo_b), 2047);
    chk("ceil_plus1_ov", int'(ov_b), 1);

    // Single edge landing on the terminal cycle of the short gate.
    burst_n = 0;
    wait_upd(0, 200, n);
    burst_start = cyc + 97; burst_n = 1;
    wait_upd(0, 200, n);
    chk("terminal_edge_fo", int'(fo_a), 1);
    wait_upd(0, 200, n);
    chk("after_terminal_fo", int'(fo_a), 0);

    // Enable drop mid-window.
    burst_n = 0; period = 10; ph0 = cyc;
    wait_upd(0, 200, n);
    wait_upd(0, 200, n);
    chk("pre_drop_fo", int'(fo_a), 10);
    repeat (40) @(posedge clock);
    #1; en = 1'b0;
    n_up = 0;
    repeat (200) begin
      @(posedge clock);
      #1;
      if (up_a) n_up++;
    end
    chk("idle_updates", n_up, 0);
    chk("idle_hold_fo", int'(fo_a), 10);
    en = 1'b1;
    wait_upd(0, 200, n);
    chk("reenable_latency", n, 101);
    chk("reenable_fo", int'(fo_a), 10);
    @(posedge clock);
    #1;
    chk("update_width", int'(up_a), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Measures the frequency of the tone-generator square wave and produces the 11-bit binary value shown on the 4-digit seven-segment display path.
- Counts rising edges of sig_in over a fixed gate window, derived from the system clock.
- At the end of each window, publishes the count as a registered, saturated 11-bit value.
- Its freq_out drives the display block's 11-bit entry input directly.

Parameters:
- GATE_CYCLES, 50000000: clock cycles per measurement window (1 s at 50 MHz); must be >= 4.
- MAX_COUNT, 2047: saturation ceiling for published count; must fit in 11 bits.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- sig_in  input  1  asynchronous square wave to be measured
- enable  input  1  high = measure; low = idle, hold last result
- freq_out  output  11  last completed window's edge count, saturated; feeds display entry
- overflow  output  1  high if last completed window exceeded MAX_COUNT
- update  output  1  one-cycle pulse when freq_out/overflow are refreshed

Behaviour:
- Reset (async, active-high):
  - freq_out=0, overflow=0, update=0.
  - Gate counter=0, edge counter=0, sync flops=0, FSM=IDLE.
  - Reset asserted mid-window discards the partial window. No update pulse is produced on reset exit.
- Input conditioning:
  - sig_in passes through a 2-flop synchronizer, then a third flop for edge detection.
  - A rising edge registers as edge_p=1 for one cycle, 3 cycles after the sig_in rise.
  - Falling edges are ignored.
- FSM states: IDLE, GATE.
  - IDLE: counters held at 0; outputs hold. If enable=1, go to GATE next cycle with gate_cnt=0.
  - GATE: gate_cnt increments by 1 per cycle. edge_cnt increments on edge_p; it saturates at MAX_COUNT and sets a sticky window_ovf.
  - Terminal cycle (gate_cnt==GATE_CYCLES-1):
    - An edge_p in this cycle is included in the result.
    - Next cycle: freq_out<=final count, overflow<=window_ovf, update=1.
    - In that same next cycle gate_cnt, edge_cnt and window_ovf are reset, and the new window begins immediately. The window is exactly GATE_CYCLES cycles long with no dead cycle.
  - enable=0 in GATE: return to IDLE next cycle and discard the partial window; freq_out/overflow hold and no update pulse is produced.
    - Exception: if enable falls on the terminal cycle, that window still publishes.
- Width rules:
  - gate_cnt width is clog2(GATE_CYCLES).
  - edge_cnt is 11 bits and never wraps (saturating).
  - The ceiling is a count of MAX_COUNT with window_ovf=1.
  - Exactly MAX_COUNT edges gives overflow=0; MAX_COUNT+1 or more gives overflow=1.
- update is high for exactly one cycle per completed window and is never asserted while in IDLE.
- freq_out changes only in the update cycle.

Decomposition:
- Shared package freq_meter_pkg holds:
  - FREQ_W=11
  - default GATE_CYCLES
  - default MAX_COUNT
  - FSM state encoding constants ST_IDLE, ST_GATE
- One sub-module: sync_edge_detect.
  - Ports: clock, reset, async_in, rise_p.
  - Implements the 2-flop synchronizer plus rising-edge detect.
  - Reusable for the push-button inputs elsewhere in the design.

Test Plan:
- Reset mid-window, GATE_CYCLES=100, sig_in period 10:
  - Run 50 cycles, pulse reset for 3 cycles.
  - freq_out=0, overflow=0, no update.
  - The first update arrives exactly 101 cycles after enable is sampled in GATE.
- Steady tone, GATE_CYCLES=100, enable=1, sig_in period 10 cycles (50% duty):
  - From the second window onward, every update shows freq_out=10, overflow=0.
  - update pulses every 100 cycles, each exactly 1 cycle wide.
- Saturation, GATE_CYCLES=5000, sig_in period 2:
  - 2500 edges per window gives freq_out=2047, overflow=1.
  - Switch to period 10 (500 edges): the next full window gives freq_out=500, overflow=0.
- Exact ceiling, GATE_CYCLES=5000:
  - Drive exactly 2047 edges in one window: freq_out=2047, overflow=0.
  - Drive 2048 edges: freq_out=2047, overflow=1.
- Enable drop:
  - With freq_out=10, deassert enable at gate_cnt=40: no update, freq_out stays 10.
  - Reassert enable: the next update comes 101 cycles later with a fresh count.
- Terminal-cycle edge, GATE_CYCLES=100:
  - Place a single sig_in rise so edge_p lands on gate_cnt==99.
  - That window publishes freq_out=1; the following window publishes freq_out=0.
